gpio_pin_ctrl: RTL

GPIO_PIN_CTRL -- requirements
Module: gpio_pin_ctrl

---
 rtl/gpio_pkg.sv | 6 +
 rtl/bit_sync.sv | 16 +
 rtl/gpio_pin_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: debouncer state type and default pin-controller parameters
package gpio_pkg;
    typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} deb_state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer for one asynchronous bit, clearing to 0
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk) begin
        if (!resetn) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: registered pad drive plus synchronized, debounced pin readback with edge strobes
module gpio_pin_ctrl
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic io_iosel,
    input  logic io_out,
    output logic io_in,
    input  logic pin_in,
    output logic pin_oe,
    output logic pin_out,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit DIRECT = DEBOUNCE_CYCLES == 1;
    deb_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic sync_q, io_d, rise_d, fall_d;
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .resetn(resetn),
        .d(pin_in),
        .q(sync_q)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= STABLE_LO;
            cnt <= '0;
            io_in <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            pin_oe <= 1'b0;
            pin_out <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            io_in <= io_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            pin_oe <= io_iosel;
            pin_out <= io_out;
        end
    end
    // cnt holds the number of candidate samples seen so far; it is 0 in STABLE states
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        case (state)
            STABLE_LO: if (sync_q) begin
                state_d = DIRECT ? STABLE_HI : CHECK_HI;
                cnt_d = DIRECT ? '0 : CW'(1);
            end
            STABLE_HI: if (!sync_q) begin
                state_d = DIRECT ? STABLE_LO : CHECK_LO;
                cnt_d = DIRECT ? '0 : CW'(1);
            end
            CHECK_HI: begin
                state_d = !sync_q ? STABLE_LO : cnt == LAST ? STABLE_HI : CHECK_HI;
                cnt_d = (!sync_q || cnt == LAST) ? '0 : cnt + 1'b1;
            end
            CHECK_LO: begin
                state_d = sync_q ? STABLE_HI : cnt == LAST ? STABLE_LO : CHECK_LO;
                cnt_d = (sync_q || cnt == LAST) ? '0 : cnt + 1'b1;
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d = '0;
            end
        endcase
    end
    always_comb begin
        io_d = state_d == STABLE_HI || state_d == CHECK_LO;
        rise_d = io_d && !io_in;
        fall_d = !io_d && io_in;
    end
endmodule
